// File: rtl/sram_dma.sv
// sram_dma: slot-driven block copy / fill engine on the SRAM arbiter port.
// Copies move data in chunks of up to FIFO_DEPTH words: read the chunk into
// a small buffer, drain the last read's data in one req=0 slot, then write
// the chunk back out. Fill mode writes a constant pattern, one word per slot.
// All request outputs are registered. After the command edge they change
// only on cyc edges, so they stay stable for a whole slot.
module sram_dma #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc,
    input  logic        cmd_start,
    input  logic        cmd_mode,
    input  logic [20:0] cmd_src,
    input  logic [20:0] cmd_dst,
    input  logic [9:0]  cmd_len,
    input  logic [15:0] cmd_fill,
    output logic        busy,
    output logic        done,
    output logic        req,
    output logic [20:0] addr,
    output logic [15:0] wrdata,
    output logic [1:0]  bsel,
    output logic        rnw,
    input  logic [15:0] sram_do
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [10:0] DEPTH11 = 11'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RD, RDLAST, WR, FIN} state_t;

    state_t        state_q, state_d;
    logic [20:0]   src_q, src_d, dst_q, dst_d;
    logic [10:0]   rem_q, rem_d;        // words left, 1..1024
    logic [15:0]   pat_q, pat_d;
    logic          mode_q, mode_d;      // 1 = fill
    logic [CW-1:0] chunk_q, chunk_d;    // words in current chunk
    logic [CW-1:0] rdcnt_q, rdcnt_d;    // reads issued in current chunk

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;
    logic [15:0]   head, head_next;

    logic          busy_d, done_d, req_d, rnw_d;
    logic [20:0]   addr_d;
    logic [15:0]   wrdata_d;
    logic [1:0]   bsel_d;

    function automatic logic [CW-1:0] chunk_of(input logic [10:0] r);
        return (r >= DEPTH11) ? CW'(FIFO_DEPTH) : CW'(r);
    endfunction

    assign head      = mem[rp_q];
    assign head_next = mem[rp_q + PW'(1)];

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        pat_d    = pat_q;
        mode_d   = mode_q;
        chunk_d  = chunk_q;
        rdcnt_d  = rdcnt_q;
        busy_d   = busy;
        done_d   = 1'b0;
        req_d    = req;
        rnw_d    = rnw;
        addr_d   = addr;
        wrdata_d = wrdata;
        bsel_d   = bsel;
        push     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: if (cmd_start) begin
                src_d  = cmd_src;
                dst_d  = cmd_dst;
                rem_d  = (cmd_len == 10'd0) ? 11'd1024 : {1'b0, cmd_len};
                pat_d  = cmd_fill;
                mode_d = cmd_mode;
                busy_d = 1'b1;
                req_d  = 1'b1;
                bsel_d = 2'b11;
                if (cmd_mode) begin
                    state_d  = WR;
                    rnw_d    = 1'b0;
                    addr_d   = cmd_dst;
                    wrdata_d = cmd_fill;
                end else begin
                    state_d = RD;
                    rnw_d   = 1'b1;
                    addr_d  = cmd_src;
                    chunk_d = chunk_of((cmd_len == 10'd0) ? 11'd1024 : {1'b0, cmd_len});
                    rdcnt_d = CW'(1);
                end
            end
            RD: if (cyc) begin
                // data on sram_do belongs to the read of the previous slot
                push  = (rdcnt_q != CW'(1));
                src_d = src_q + 21'd1;
                if (rdcnt_q < chunk_q) begin
                    addr_d  = src_q + 21'd1;
                    rdcnt_d = rdcnt_q + CW'(1);
                end else begin
                    state_d = RDLAST;
                    req_d   = 1'b0;
                    bsel_d  = 2'b00;
                end
            end
            RDLAST: if (cyc) begin
                push     = 1'b1;
                state_d  = WR;
                req_d    = 1'b1;
                rnw_d    = 1'b0;
                bsel_d   = 2'b11;
                addr_d   = dst_q;
                // single-word chunk: the word being pushed is the head
                wrdata_d = (cnt_q == '0) ? sram_do : head;
            end
            WR: if (cyc) begin
                pop   = !mode_q;
                dst_d = dst_q + 21'd1;
                rem_d = rem_q - 11'd1;
                if (mode_q ? (rem_q != 11'd1) : (cnt_q != CW'(1))) begin
                    addr_d   = dst_q + 21'd1;
                    wrdata_d = mode_q ? pat_q : head_next;
                end else if (rem_q != 11'd1) begin
                    state_d = RD;
                    rnw_d   = 1'b1;
                    addr_d  = src_q;
                    chunk_d = chunk_of(rem_q - 11'd1);
                    rdcnt_d = CW'(1);
                end else begin
                    state_d = FIN;
                    req_d   = 1'b0;
                    rnw_d   = 1'b1;
                    bsel_d  = 2'b00;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        wp_d  = push ? wp_q + PW'(1) : wp_q;
        rp_d  = pop  ? rp_q + PW'(1) : rp_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    // State, command and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            pat_q   <= '0;
            mode_q  <= 1'b0;
            chunk_q <= '0;
            rdcnt_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            req     <= 1'b0;
            rnw     <= 1'b1;
            addr    <= '0;
            wrdata  <= '0;
            bsel    <= 2'b00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
            mode_q  <= mode_d;
            chunk_q <= chunk_d;
            rdcnt_q <= rdcnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            req     <= req_d;
            rnw     <= rnw_d;
            addr    <= addr_d;
            wrdata  <= wrdata_d;
            bsel    <= bsel_d;
        end
    end

    // Chunk buffer storage; contents are don't-care once pointers reset
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wp_q] <= sram_do;
    end

endmodule

// File: tb/tb_sram_dma.sv
// Directed bench for sram_dma: slot generator, SRAM responder that returns
// the read address as data, and a log of every consumed slot.
module tb_sram_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_mode = 1'b0;
    logic [20:0] cmd_src = '0;
    logic [20:0] cmd_dst = '0;
    logic [9:0]  cmd_len = '0;
    logic [15:0] cmd_fill = '0;
    logic        busy, done, req, rnw;
    logic [20:0] addr;
    logic [15:0] wrdata;
    logic [1:0]  bsel;
    logic [15:0] sram_do = '0;

    sram_dma #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cyc(cyc), .cmd_start(cmd_start),
        .cmd_mode(cmd_mode), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_fill(cmd_fill), .busy(busy), .done(done),
        .req(req), .addr(addr), .wrdata(wrdata), .bsel(bsel), .rnw(rnw),
        .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int clk_n = 0;
    int period = 0;
    int slots, nidle, nrd, ndone, done_clk, last_slot_clk;
    logic busy_after;
    logic prev_done = 1'b0;
    logic start_next = 1'b0;
    logic rst_next = 1'b0;
    logic rd_pend = 1'b0;
    logic [20:0] rd_a = '0;
    logic [20:0] wa[$];
    logic [15:0] wd[$];
    logic [1:0]  wb[$];

    // One clock: sample DUT at the negedge, then drive inputs for the next posedge
    task automatic step();
        @(negedge clk);
        clk_n++;
        if (prev_done) busy_after = busy;
        prev_done = done;
        if (done) begin ndone++; done_clk = clk_n; end
        rst_n = rst_next;
        cmd_start = start_next;
        start_next = 1'b0;
        cyc = (period != 0) && (clk_n % period == 0);
        if (cyc) begin
            sram_do = rd_pend ? rd_a[15:0] : 16'hDEAD;
            rd_pend = 1'b0;
            if (busy && !done && rst_n) begin
                slots++;
                last_slot_clk = clk_n;
                if (!req) nidle++;
                else if (rnw) begin rd_pend = 1'b1; rd_a = addr; nrd++; end
                else begin wa.push_back(addr); wd.push_back(wrdata); wb.push_back(bsel); end
            end
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wb.delete();
        slots = 0; nidle = 0; nrd = 0; ndone = 0;
        done_clk = -1; last_slot_clk = -1; busy_after = 1'b1;
    endtask

    // Issue a command and run to completion; inj >= 0 fires a second start mid-run
    task automatic run_cmd(input logic m, input logic [20:0] s, input logic [20:0] d,
                           input logic [9:0] l, input logic [15:0] f, input int p, input int inj);
        clear_log();
        period = p;
        cmd_mode = m; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_fill = f;
        start_next = 1'b1;
        step();
        for (int i = 0; i < 20000; i++) begin
            if (i == inj) begin
                cmd_mode = ~m; cmd_src = 21'h07000; cmd_dst = 21'h0ABCD;
                cmd_len = 10'd7; cmd_fill = 16'h1234; start_next = 1'b1;
            end
            step();
            if (ndone != 0) break;
        end
        checks++;
        if (ndone == 0) $display("FAIL run_timeout got no done want done");
        else passed++;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_next = 1'b0; period = 0;
        step(); step(); step();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
        checks++; if (req !== 1'b0) $display("FAIL reset_req got %0b want 0", req); else passed++;
        checks++; if (rnw !== 1'b1) $display("FAIL reset_rnw got %0b want 1", rnw); else passed++;
        checks++; if (addr !== 21'h0) $display("FAIL reset_addr got %h want 0", addr); else passed++;
        checks++; if (wrdata !== 16'h0) $display("FAIL reset_wrdata got %h want 0", wrdata); else passed++;
        checks++; if (bsel !== 2'b00) $display("FAIL reset_bsel got %b want 00", bsel); else passed++;
        rst_next = 1'b1;
        step(); step();
    endtask

    task automatic test_fill();
        run_cmd(1'b1, 21'h0, 21'h00100, 10'd4, 16'hA55A, 16, -1);
        checks++; if (wa.size() != 4) $display("FAIL fill_nwr got %0d want 4", wa.size()); else passed++;
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 21'h00100 + 21'(i)) $display("FAIL fill_addr%0d got %h want %h", i, wa[i], 21'h00100 + 21'(i)); else passed++;
            checks++; if (wd[i] !== 16'hA55A) $display("FAIL fill_data%0d got %h want a55a", i, wd[i]); else passed++;
            checks++; if (wb[i] !== 2'b11) $display("FAIL fill_bsel%0d got %b want 11", i, wb[i]); else passed++;
        end
        checks++; if (slots != 4) $display("FAIL fill_slots got %0d want 4", slots); else passed++;
        checks++; if (done_clk != last_slot_clk + 1) $display("FAIL fill_done_time got %0d want %0d", done_clk, last_slot_clk + 1); else passed++;
        checks++; if (ndone != 1) $display("FAIL fill_done_width got %0d want 1", ndone); else passed++;
        checks++; if (busy_after !== 1'b0) $display("FAIL fill_busy_after got %0b want 0", busy_after); else passed++;
    endtask

    task automatic test_copy3();
        run_cmd(1'b0, 21'h00200, 21'h00300, 10'd3, 16'h0, 4, -1);
        checks++; if (slots != 7) $display("FAIL copy3_slots got %0d want 7", slots); else passed++;
        checks++; if (nidle != 1) $display("FAIL copy3_idle got %0d want 1", nidle); else passed++;
        checks++; if (nrd != 3) $display("FAIL copy3_reads got %0d want 3", nrd); else passed++;
        checks++; if (wa.size() != 3) $display("FAIL copy3_nwr got %0d want 3", wa.size()); else passed++;
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 21'h00300 + 21'(i)) $display("FAIL copy3_addr%0d got %h want %h", i, wa[i], 21'h00300 + 21'(i)); else passed++;
            checks++; if (wd[i] !== 16'h0200 + 16'(i)) $display("FAIL copy3_data%0d got %h want %h", i, wd[i], 16'h0200 + 16'(i)); else passed++;
        end
        checks++; if (done_clk != last_slot_clk + 1) $display("FAIL copy3_done_time got %0d want %0d", done_clk, last_slot_clk + 1); else passed++;
    endtask

    task automatic test_copy10();
        run_cmd(1'b0, 21'h01230, 21'h04560, 10'd10, 16'h0, 3, -1);
        checks++; if (slots != 22) $display("FAIL copy10_slots got %0d want 22", slots); else passed++;
        checks++; if (nidle != 2) $display("FAIL copy10_idle got %0d want 2", nidle); else passed++;
        checks++; if (wa.size() != 10) $display("FAIL copy10_nwr got %0d want 10", wa.size()); else passed++;
        for (int i = 0; i < 10 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 21'h04560 + 21'(i)) $display("FAIL copy10_addr%0d got %h want %h", i, wa[i], 21'h04560 + 21'(i)); else passed++;
            checks++; if (wd[i] !== 16'h1230 + 16'(i)) $display("FAIL copy10_data%0d got %h want %h", i, wd[i], 16'h1230 + 16'(i)); else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [20:0] exp_a [3];
        exp_a[0] = 21'h1FFFFE; exp_a[1] = 21'h1FFFFF; exp_a[2] = 21'h000000;
        run_cmd(1'b1, 21'h0, 21'h1FFFFE, 10'd3, 16'h5A5A, 2, -1);
        checks++; if (wa.size() != 3) $display("FAIL wrap_nwr got %0d want 3", wa.size()); else passed++;
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %h want %h", i, wa[i], exp_a[i]); else passed++;
        end
    endtask

    task automatic test_len0();
        run_cmd(1'b1, 21'h0, 21'h01000, 10'd0, 16'hC3C3, 1, -1);
        checks++; if (wa.size() != 1024) $display("FAIL len0_nwr got %0d want 1024", wa.size()); else passed++;
        checks++; if (wa.size() == 1024 && wa[1023] !== 21'h013FF) $display("FAIL len0_last got %h want 013ff", wa[1023]); else passed++;
        checks++; if (done_clk != last_slot_clk + 1) $display("FAIL len0_done_time got %0d want %0d", done_clk, last_slot_clk + 1); else passed++;
    endtask

    task automatic test_busy_ignore();
        run_cmd(1'b0, 21'h00200, 21'h00300, 10'd3, 16'h0, 4, 5);
        checks++; if (slots != 7) $display("FAIL ign_slots got %0d want 7", slots); else passed++;
        checks++; if (wa.size() != 3) $display("FAIL ign_nwr got %0d want 3", wa.size()); else passed++;
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 21'h00300 + 21'(i)) $display("FAIL ign_addr%0d got %h want %h", i, wa[i], 21'h00300 + 21'(i)); else passed++;
            checks++; if (wd[i] !== 16'h0200 + 16'(i)) $display("FAIL ign_data%0d got %h want %h", i, wd[i], 16'h0200 + 16'(i)); else passed++;
        end
        for (int i = 0; i < 10; i++) step();
        checks++; if (busy !== 1'b0 || ndone != 1) $display("FAIL ign_idle got busy=%0b dones=%0d want busy=0 dones=1", busy, ndone); else passed++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        period = 2;
        cmd_mode = 1'b0; cmd_src = 21'h00600; cmd_dst = 21'h00700; cmd_len = 10'd10;
        start_next = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        rst_next = 1'b0;
        step();
        rst_next = 1'b1;
        rd_pend = 1'b0;
        step();
        checks++; if (req !== 1'b0) $display("FAIL rstmid_req got %0b want 0", req); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy); else passed++;
        checks++; if (bsel !== 2'b00) $display("FAIL rstmid_bsel got %b want 00", bsel); else passed++;
        step(); step();
        run_cmd(1'b0, 21'h00440, 21'h00550, 10'd5, 16'h0, 3, -1);
        checks++; if (slots != 11) $display("FAIL rstmid_slots got %0d want 11", slots); else passed++;
        checks++; if (wa.size() != 5) $display("FAIL rstmid_nwr got %0d want 5", wa.size()); else passed++;
        for (int i = 0; i < 5 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 21'h00550 + 21'(i)) $display("FAIL rstmid_addr%0d got %h want %h", i, wa[i], 21'h00550 + 21'(i)); else passed++;
            checks++; if (wd[i] !== 16'h0440 + 16'(i)) $display("FAIL rstmid_data%0d got %h want %h", i, wd[i], 16'h0440 + 16'(i)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy3();
        test_copy10();
        test_wrap();
        test_len0();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sram_dma.md
# sram_dma

Block-copy and fill engine that initiates on the slot-based SRAM software interface (cyc/req/addr/wrdata/bsel/rnw, read data on sram_do). It sits beside the CPU and video clients on the SRAM arbiter port, and moves 16-bit words SRAM-to-SRAM through a small internal buffer or fills a region with a constant. One access is issued per cyc slot.

## Interface
- FIFO_DEPTH, 8: chunk buffer depth in words; power of two, 2..64.

- clk  in  1  system clock
- rst_n  in  1  reset; **synchronous, active-low**
- cyc  in  1  slot strobe from SRAM controller; one-clock pulse per access slot
- cmd_start  in  1  one-clock command strobe; honoured only when busy=0
- cmd_mode  in  1  0 = copy, 1 = fill
- cmd_src  in  21  copy source word address
- cmd_dst  in  21  destination word address
- cmd_len  in  10  word count; 0 means 1024
- cmd_fill  in  16  fill pattern
- busy  out  1  command in progress
- done  out  1  one-clock pulse at completion
- req  out  1  access request for the current slot
- addr  out  21  access word address
- wrdata  out  16  write data
- bsel  out  2  byte select; always 2'b11 when req=1 and rnw=0
- rnw  out  1  1 = read, 0 = write
- sram_do  in  16  read data from the controller

## Operation
- States: IDLE, RD, RDLAST, WR, FIN.
- Command registers (src, dst, remaining count, pattern, mode) latch on cmd_start in IDLE. cmd_start while busy is ignored.
- Request outputs are registered:
  - They change on the cmd_start edge.
  - After that they change only on clock edges where cyc=1.
  - They therefore stay stable from one cyc strobe to the next. The controller samples req/rnw/bsel/addr at cyc and uses wrdata later in the slot.
- A slot is consumed on each clock with cyc=1 while busy.
- Fill mode:
  - IDLE→WR with req=1, rnw=0, addr=dst, wrdata=cmd_fill.
  - Each consumed slot: dst+1, remaining−1.
  - After the last write slot, go to FIN.
- Copy mode works in chunks of n = min(remaining, FIFO_DEPTH).
  - IDLE→RD with req=1, rnw=1, addr=src.
  - RD, each consumed slot: if the previous slot was a read, push sram_do into the FIFO. If fewer than n reads have been issued, src+1 and present the next read. After the nth read, go to RDLAST with req=0.
  - RDLAST, next consumed slot: push sram_do (data of the nth read). Then go to WR with req=1, rnw=0, addr=dst, wrdata=FIFO head.
  - WR, each consumed slot: pop, dst+1, remaining−1.
    - If the chunk is not finished, present the next word.
    - Else if remaining>0, go to RD (addr=src, which has already advanced).
    - Else go to FIN.
- Read data for a read issued in slot k is valid on sram_do at the cyc of slot k+1 and is sampled only there.
- FIN: req=0, done=1 for one clock, busy=0 on the following clock, then IDLE.
- Address arithmetic is modulo 2^21: 21'h1FFFFF+1 = 0, no fault.
- Overlapping src/dst regions are not detected. Results are defined only per chunk order.

## Timing
- Reset values: busy=0, done=0, req=0, rnw=1, addr=0, wrdata=0, bsel=2'b00; FIFO empty; state IDLE.
- Reset during an operation aborts the command. All outputs return to reset values on the reset edge. A partially issued slot is not retracted by the controller but is not counted.
- busy=1 from the clock after cmd_start.
- If cmd_start coincides with cyc=1, that slot is not used.
- Slot cost:
  - Fill of L words: L slots.
  - Copy: 2n+1 slots per chunk. The extra slot is the RDLAST drain with req=0.
- done asserts on the clock after the final consumed WR slot.
- cmd_len=0 transfers 1024 words.
- FIFO never overflows: the FIFO holds at most n ≤ FIFO_DEPTH words and is empty at every RD entry.

## Test plan
- Fill, dst=21'h00100, len=4, pattern=16'hA55A, cyc every 16 clocks:
  - 4 write slots to addresses 0x100..0x103, all wrdata=A55A, bsel=11.
  - done pulses on the clock after slot 4.
- Copy, src=0x200, dst=0x300, len=3, responder model returns addr[15:0] on sram_do:
  - 3 reads, 1 req=0 slot, 3 writes of 0x0200/0x0201/0x0202 to 0x300..0x302.
  - 7 slots total.
- Copy, len=10, FIFO_DEPTH=8:
  - Chunk sizes 8 then 2; 16+1+4+1 = 22 slots.
  - Destination data matches source order.
- Wrap: fill dst=21'h1FFFFE, len=3 → writes to 1FFFFE, 1FFFFF, 000000.
- cmd_start while busy with different addresses → ignored; the original transfer completes unchanged.
- rst_n low for one clock mid-copy:
  - req=0, busy=0 on the next clock.
  - A new cmd_start afterwards runs correctly from an empty FIFO.
